// File: rtl/gray_sync_pkg.sv
// Shared helpers for the Gray pointer synchroniser bank: width calc, popcount, Gray decode.
// Helpers operate on a fixed GS_MAX_W-bit vector; callers zero-extend narrower pointers.
package gray_sync_pkg;

  localparam int GS_MAX_W = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int popcount(input logic [GS_MAX_W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < GS_MAX_W; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Zero-extended Gray input decodes to a zero-extended binary result.
  function automatic logic [GS_MAX_W-1:0] gray2bin(input logic [GS_MAX_W-1:0] g);
    logic [GS_MAX_W-1:0] b;
    b = '0;
    b[GS_MAX_W-1] = g[GS_MAX_W-1];
    for (int i = GS_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync_bank_sync_chain.sv
// Single-bit STAGES-deep metastability chain with asynchronous active-high reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stg <= '0;
    else     stg <= {stg[STAGES-2:0], d};
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/gray_sync_bank.sv
// Multi-stage Gray pointer synchroniser with settle flag, change strobe and sticky violation flag.
// Define GRAY_SYNC_BIN_EN to add the registered Gray-to-binary output BIN_OUT.
module gray_sync_bank
  import gray_sync_pkg::*;
#(
  parameter int P_SIZE = 4,
  parameter int STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [P_SIZE-1:0] ASYNC_IN,
  input  logic              ERR_CLR,
  output logic [P_SIZE-1:0] SYNC_OUT,
  output logic              CHG_PULSE,
  output logic              SYNC_VALID,
  output logic              GRAY_ERR
`ifdef GRAY_SYNC_BIN_EN
  ,
  output logic [P_SIZE-1:0] BIN_OUT
`endif
);

  localparam int               CNT_W   = clog2(STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STAGES + 1);

  logic [P_SIZE-1:0] prev;
  logic [P_SIZE-1:0] diff;
  logic [CNT_W-1:0]  cnt;
  logic              violation;

  for (genvar i = 0; i < P_SIZE; i++) begin : g_bit
    sync_chain #(.STAGES(STAGES)) u_chain (
      .CLK (CLK),
      .RST (RST),
      .d   (ASYNC_IN[i]),
      .q   (SYNC_OUT[i])
    );
  end

  assign diff       = SYNC_OUT ^ prev;
  assign SYNC_VALID = (cnt == CNT_MAX);
  // Reset-flush transients are not real pointer moves, so only flag once settled.
  assign violation  = SYNC_VALID && (popcount(GS_MAX_W'(diff)) > 1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev      <= '0;
      cnt       <= '0;
      CHG_PULSE <= 1'b0;
      GRAY_ERR  <= 1'b0;
    end else begin
      prev      <= SYNC_OUT;
      CHG_PULSE <= |diff;
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (violation)    GRAY_ERR <= 1'b1;
      else if (ERR_CLR) GRAY_ERR <= 1'b0;
    end
  end

`ifdef GRAY_SYNC_BIN_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) BIN_OUT <= '0;
    else     BIN_OUT <= P_SIZE'(gray2bin(GS_MAX_W'(SYNC_OUT)));
  end
`endif

endmodule

// File: tb/tb_gray_sync_bank.sv
// Directed bench for gray_sync_bank: STAGES=2 instance (dut_a) and STAGES=3 instance (dut_b).
module tb_gray_sync_bank;

  logic       CLK = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] ain, bin_in;
  logic       err_clr_a, err_clr_b;
  logic [3:0] sync_a, sync_b;
  logic       chg_a, chg_b, valid_a, valid_b, err_a, err_b;
`ifdef GRAY_SYNC_BIN_EN
  logic [3:0] bout_a, bout_b;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  gray_sync_bank #(.P_SIZE(4), .STAGES(2)) dut_a (
    .CLK        (CLK),
    .RST        (rst_a),
    .ASYNC_IN   (ain),
    .ERR_CLR    (err_clr_a),
    .SYNC_OUT   (sync_a),
    .CHG_PULSE  (chg_a),
    .SYNC_VALID (valid_a),
    .GRAY_ERR   (err_a)
`ifdef GRAY_SYNC_BIN_EN
    ,
    .BIN_OUT    (bout_a)
`endif
  );

  gray_sync_bank #(.P_SIZE(4), .STAGES(3)) dut_b (
    .CLK        (CLK),
    .RST        (rst_b),
    .ASYNC_IN   (bin_in),
    .ERR_CLR    (err_clr_b),
    .SYNC_OUT   (sync_b),
    .CHG_PULSE  (chg_b),
    .SYNC_VALID (valid_b),
    .GRAY_ERR   (err_b)
`ifdef GRAY_SYNC_BIN_EN
    ,
    .BIN_OUT    (bout_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] b;

    rst_a = 1'b1; rst_b = 1'b1;
    ain = 4'b1111; bin_in = 4'b1111;
    err_clr_a = 1'b0; err_clr_b = 1'b0;

    // Reset held three cycles with all-ones input
    wait_cycles(3);
    chk("rst_sync", 32'(sync_a), 32'h0);
    chk("rst_chg", 32'(chg_a), 32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    chk("rst_sync_b", 32'(sync_b), 32'h0);
`ifdef GRAY_SYNC_BIN_EN
    chk("rst_bin", 32'(bout_a), 32'h0);
`endif
    ain = 4'b0000; bin_in = 4'b0000;
    rst_a = 1'b0; rst_b = 1'b0;
    tick(); chk("valid_e1", 32'(valid_a), 32'h0);
    tick(); chk("valid_e2", 32'(valid_a), 32'h0);
    tick(); chk("valid_e3", 32'(valid_a), 32'h1);
    chk("valid_b_e3", 32'(valid_b), 32'h0);
    tick(); chk("valid_b_e4", 32'(valid_b), 32'h1);

    // Latency 0000 -> 0001
    ain = 4'b0001;
    tick(); chk("lat_k", 32'(sync_a), 32'h0);
    tick(); chk("lat_k1", 32'(sync_a), 32'h1);
    chk("lat_chg_k1", 32'(chg_a), 32'h0);
    tick(); chk("lat_chg_k2", 32'(chg_a), 32'h1);
`ifdef GRAY_SYNC_BIN_EN
    chk("lat_bin_k2", 32'(bout_a), 32'h1);
`endif
    tick(); chk("lat_chg_k3", 32'(chg_a), 32'h0);

    // Gray count sweep through the wrap back to zero
    for (int i = 2; i <= 16; i++) begin
      b = 4'(i);
      g = b ^ (b >> 1);
      ain = g;
      wait_cycles(2);
      chk("sweep_sync", 32'(sync_a), 32'(g));
      tick();
      chk("sweep_chg", 32'(chg_a), 32'h1);
      chk("sweep_err", 32'(err_a), 32'h0);
`ifdef GRAY_SYNC_BIN_EN
      chk("sweep_bin", 32'(bout_a), 32'(b));
`endif
      tick();
      chk("sweep_chg_off", 32'(chg_a), 32'h0);
    end

    // Back-to-back single-bit changes give consecutive pulses
    ain = 4'b0001;
    tick();
    ain = 4'b0011;
    tick(); chk("b2b_sync1", 32'(sync_a), 32'h1);
    tick(); chk("b2b_sync2", 32'(sync_a), 32'h3);
    chk("b2b_chg1", 32'(chg_a), 32'h1);
    tick(); chk("b2b_chg2", 32'(chg_a), 32'h1);
    tick(); chk("b2b_chg3", 32'(chg_a), 32'h0);
    chk("b2b_err", 32'(err_a), 32'h0);
    ain = 4'b0001; wait_cycles(4);
    ain = 4'b0000; wait_cycles(4);
    chk("pre_vio_err", 32'(err_a), 32'h0);

    // Violation 0000 -> 0011, clear, then clear colliding with a new violation
    ain = 4'b0011;
    tick();
    tick(); chk("vio_sync", 32'(sync_a), 32'h3);
    chk("vio_err_early", 32'(err_a), 32'h0);
    tick(); chk("vio_err", 32'(err_a), 32'h1);
    wait_cycles(3); chk("vio_sticky", 32'(err_a), 32'h1);
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    chk("vio_clr", 32'(err_a), 32'h0);
    ain = 4'b0000;
    tick();
    tick();
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    chk("vio_set_wins", 32'(err_a), 32'h1);
    tick(); chk("vio_set_hold", 32'(err_a), 32'h1);

    // Mid-operation asynchronous reset between edges
    ain = 4'b0110;
    wait_cycles(2);
    chk("mid_pre_sync", 32'(sync_a), 32'h6);
    #2 rst_a = 1'b1;
    #1;
    chk("mid_sync", 32'(sync_a), 32'h0);
    chk("mid_chg", 32'(chg_a), 32'h0);
    chk("mid_valid", 32'(valid_a), 32'h0);
    chk("mid_err", 32'(err_a), 32'h0);
`ifdef GRAY_SYNC_BIN_EN
    chk("mid_bin", 32'(bout_a), 32'h0);
`endif
    ain = 4'b1111;
    wait_cycles(2);
    chk("mid_hold_sync", 32'(sync_a), 32'h0);
    rst_a = 1'b0;
    tick(); chk("mid_valid_e1", 32'(valid_a), 32'h0);
    tick(); chk("mid_valid_e2", 32'(valid_a), 32'h0);
    chk("mid_sync_e2", 32'(sync_a), 32'hf);
    tick(); chk("mid_valid_e3", 32'(valid_a), 32'h1);
    chk("mid_chg_e3", 32'(chg_a), 32'h1);
    chk("mid_err_ignored", 32'(err_a), 32'h0);

    // STAGES=3 latency
    bin_in = 4'b0001;
    tick();
    tick(); chk("s3_lat_k1", 32'(sync_b), 32'h0);
    tick(); chk("s3_lat_k2", 32'(sync_b), 32'h1);
    chk("s3_chg_k2", 32'(chg_b), 32'h0);
    tick(); chk("s3_chg_k3", 32'(chg_b), 32'h1);
    chk("s3_err", 32'(err_b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
